// File: rtl/snax_simbacore_csr_arbiter.sv
// ---------------------------------------------------------------------------
// snax_simbacore_csr_arbiter
//
// Purpose:
//   Shares one SimbaCore CSR request/response port between NumReq upstream
//   requesters, for example the Snitch core CSR path and a descriptor loader.
//   One pending request is granted each cycle, round-robin, and is forwarded
//   downstream unchanged. The requester index of every accepted read goes
//   into an in-order ID FIFO, so each response can be routed back to the
//   requester that issued the read. Request and response paths are purely
//   combinational; the block adds no pipeline stage.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_data_i/addr_i     per-requester write data / CSR address (NumReq x 32)
//   req_write_i           per-requester write flag (1 = write, 0 = read)
//   req_valid_i/ready_o   per-requester request handshake
//   rsp_data_o            response data, broadcast to every requester
//   rsp_valid_o/ready_i   per-requester response handshake
//   csr_req_*             downstream request port
//   csr_rsp_*             downstream response port
//   outstanding_o         number of reads still waiting for a response
//   err_o                 sticky flag: a response arrived with no read pending
// ---------------------------------------------------------------------------
module snax_simbacore_csr_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntW          = $clog2(MaxOutstanding) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq*32-1:0]   req_data_i,
    input  logic [NumReq*32-1:0]   req_addr_i,
    input  logic [NumReq-1:0]      req_write_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic [NumReq*32-1:0]   rsp_data_o,
    output logic [NumReq-1:0]      rsp_valid_o,
    input  logic [NumReq-1:0]      rsp_ready_i,
    output logic [31:0]            csr_req_data_o,
    output logic [31:0]            csr_req_addr_o,
    output logic                   csr_req_write_o,
    output logic                   csr_req_valid_o,
    input  logic                   csr_req_ready_i,
    input  logic [31:0]            csr_rsp_data_i,
    input  logic                   csr_rsp_valid_i,
    output logic                   csr_rsp_ready_o,
    output logic [CntW-1:0]        outstanding_o,
    output logic                   err_o
);

    localparam int unsigned     PtrW  = $clog2(MaxOutstanding);
    localparam logic [CntW-1:0] Depth = CntW'(MaxOutstanding);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    // ------------------------------------------------------------------
    // Per-requester views of the flattened request buses
    // ------------------------------------------------------------------
    logic [31:0] addr_arr [NumReq];
    logic [31:0] data_arr [NumReq];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdxW-1:0] rr_ptr_q,   rr_ptr_d;
    logic            lock_q,     lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [PtrW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CntW-1:0] count_q,    count_d;
    logic            err_q,      err_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [IdxW:0]   rr_sum;
    logic [IdxW-1:0] rr_cand;
    logic [IdxW-1:0] rr_idx;
    logic            rr_found;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] head;
    logic            any_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic            stall;
    logic            req_fwd;
    logic            handshake;
    logic            push;
    logic            pop;

    // Round-robin search: first valid requester at or above rr_ptr_q,
    // wrapping at NumReq (NumReq need not be a power of two).
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int k = 0; k < NumReq; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
            if (rr_sum >= (IdxW+1)'(NumReq)) begin
                rr_sum = rr_sum - (IdxW+1)'(NumReq);
            end
            rr_cand = rr_sum[IdxW-1:0];
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // A locked grant stays put until its handshake completes, so the
    // downstream side never sees the request change mid-handshake.
    assign grant      = lock_q ? lock_idx_q : rr_idx;
    assign any_valid  = |req_valid_i;
    assign fifo_full  = (count_q == Depth);
    assign fifo_empty = (count_q == '0);

    // Reads need a free ID slot; a pop in the same cycle does not free one
    // early, which keeps the full flag off the response path.
    assign stall      = fifo_full & ~req_write_i[grant];
    assign req_fwd    = any_valid & ~stall;
    assign handshake  = req_fwd & csr_req_ready_i;
    assign push       = handshake & ~req_write_i[grant];

    assign head       = fifo_q[rd_ptr_q];
    assign pop        = ~fifo_empty & csr_rsp_valid_i & rsp_ready_i[head];

    // ------------------------------------------------------------------
    // Downstream request / response ports
    // ------------------------------------------------------------------
    assign csr_req_valid_o = req_fwd;
    assign csr_req_addr_o  = addr_arr[grant];
    assign csr_req_data_o  = data_arr[grant];
    assign csr_req_write_o = req_write_i[grant];

    // With nothing outstanding, a stray response is swallowed (and flagged)
    // so the downstream port can never wedge on it.
    assign csr_rsp_ready_o = fifo_empty ? csr_rsp_valid_i : rsp_ready_i[head];

    assign outstanding_o   = count_q;
    assign err_o           = err_q;

    // ------------------------------------------------------------------
    // Per-requester fan-out
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign addr_arr[gi]              = req_addr_i[gi*32 +: 32];
            assign data_arr[gi]              = req_data_i[gi*32 +: 32];
            assign req_ready_o[gi]           = handshake & (grant == IdxW'(gi));
            assign rsp_valid_o[gi]           = csr_rsp_valid_i & ~fifo_empty
                                               & (head == IdxW'(gi));
            assign rsp_data_o[gi*32 +: 32]   = csr_rsp_data_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        // Any valid request that does not complete this cycle (back-pressure
        // or stall) pins the grant; a handshake or an idle cycle releases it.
        lock_d     = any_valid & ~handshake;
        lock_idx_d = grant;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q | (csr_rsp_valid_i & fifo_empty);

        if (handshake) begin
            rr_ptr_d = (grant == LastIdx) ? '0 : grant + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // ID storage needs no reset: an entry is only read once count_q covers it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_snax_simbacore_csr_arbiter.sv
module tb_snax_simbacore_csr_arbiter;

    localparam int N  = 2;
    localparam int M  = 4;
    localparam int CW = $clog2(M) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*32-1:0]   req_data, req_addr;
    logic [N-1:0]      req_write, req_valid, req_ready;
    logic [N*32-1:0]   rsp_data;
    logic [N-1:0]      rsp_valid, rsp_ready;
    logic [31:0]       csr_req_data, csr_req_addr;
    logic              csr_req_write, csr_req_valid, csr_req_ready;
    logic [31:0]       csr_rsp_data;
    logic              csr_rsp_valid, csr_rsp_ready;
    logic [CW-1:0]     outstanding;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snax_simbacore_csr_arbiter #(
        .NumReq         (N),
        .MaxOutstanding (M)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_data_i      (req_data),
        .req_addr_i      (req_addr),
        .req_write_i     (req_write),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .rsp_data_o      (rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .csr_req_data_o  (csr_req_data),
        .csr_req_addr_o  (csr_req_addr),
        .csr_req_write_o (csr_req_write),
        .csr_req_valid_o (csr_req_valid),
        .csr_req_ready_i (csr_req_ready),
        .csr_rsp_data_i  (csr_rsp_data),
        .csr_rsp_valid_i (csr_rsp_valid),
        .csr_rsp_ready_o (csr_rsp_ready),
        .outstanding_o   (outstanding),
        .err_o           (err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_write     = '0;
        csr_req_ready = 1'b0;
        csr_rsp_valid = 1'b0;
        csr_rsp_data  = '0;
        rsp_ready     = '0;
    endtask

    // ---------------------------------------------------------------
    // Directed vectors: one row per cycle, applied in order from reset
    // ---------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [1:0]  write;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic [1:0]  rsprdy;
        logic        e_cv;
        logic [31:0] e_addr;
        logic [1:0]  e_rr;
        logic [1:0]  e_rv;
        logic        e_crr;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] w, logic rd,
                                logic rv, logic [31:0] rdat, logic [1:0] rrd,
                                logic ecv, logic [31:0] ea, logic [1:0] err_,
                                logic [1:0] erv, logic ecrr, logic [2:0] eo, logic ee);
        vec_t t;
        t.rst = r; t.valid = v; t.write = w; t.rdy = rd; t.rspv = rv; t.rspd = rdat;
        t.rsprdy = rrd; t.e_cv = ecv; t.e_addr = ea; t.e_rr = err_; t.e_rv = erv;
        t.e_crr = ecrr; t.e_out = eo; t.e_err = ee;
        return t;
    endfunction

    vec_t vecs [25];

    // Reference model state (random phase)
    int          m_rr;
    bit          m_lock;
    int          m_lidx;
    int          m_q[$];
    bit          m_err;
    bit          pend   [N];
    logic [31:0] p_addr [N];
    logic [31:0] p_data [N];
    bit          p_wr   [N];

    initial begin
        rst = 1'b1;
        req_addr = '0;
        req_data = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //          rst v     w     rdy rspv rspd          rsprdy  cv addr   rr    rv    crr out err
        vecs[0]  = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 0);
        vecs[1]  = mk(0, 2'b01, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h10, 2'b01, 2'b00, 0, 0, 0);
        vecs[2]  = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b01,  0, 32'h0,  2'b00, 2'b00, 1, 1, 0);
        vecs[3]  = mk(0, 2'b00, 2'b00, 0, 1, 32'hDEADBEEF, 2'b01,  0, 32'h0,  2'b00, 2'b01, 1, 1, 0);
        vecs[4]  = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 0);
        vecs[5]  = mk(0, 2'b10, 2'b10, 1, 0, 32'h0,        2'b00,  1, 32'h4,  2'b10, 2'b00, 0, 0, 0);
        vecs[6]  = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 0);
        vecs[7]  = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h10, 2'b01, 2'b00, 0, 0, 0);
        vecs[8]  = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h4,  2'b10, 2'b00, 0, 1, 0);
        vecs[9]  = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h10, 2'b01, 2'b00, 0, 2, 0);
        vecs[10] = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h4,  2'b10, 2'b00, 0, 3, 0);
        vecs[11] = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 4, 0);
        vecs[12] = mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        2'b00,  1, 32'h10, 2'b01, 2'b00, 0, 4, 0);
        vecs[13] = mk(0, 2'b11, 2'b00, 1, 1, 32'h1,        2'b11,  0, 32'h0,  2'b00, 2'b01, 1, 4, 0);
        vecs[14] = mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        2'b00,  1, 32'h4,  2'b10, 2'b00, 0, 3, 0);
        vecs[15] = mk(0, 2'b00, 2'b00, 0, 1, 32'h2,        2'b11,  0, 32'h0,  2'b00, 2'b10, 1, 4, 0);
        vecs[16] = mk(0, 2'b00, 2'b00, 0, 1, 32'h3,        2'b11,  0, 32'h0,  2'b00, 2'b01, 1, 3, 0);
        vecs[17] = mk(0, 2'b00, 2'b00, 0, 1, 32'h4,        2'b11,  0, 32'h0,  2'b00, 2'b10, 1, 2, 0);
        vecs[18] = mk(0, 2'b00, 2'b00, 0, 1, 32'h5,        2'b11,  0, 32'h0,  2'b00, 2'b10, 1, 1, 0);
        vecs[19] = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 0);
        vecs[20] = mk(0, 2'b00, 2'b00, 0, 1, 32'h77,       2'b00,  0, 32'h0,  2'b00, 2'b00, 1, 0, 0);
        vecs[21] = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 1);
        vecs[22] = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 1);
        vecs[23] = mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 1);
        vecs[24] = mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00,  0, 32'h0,  2'b00, 2'b00, 0, 0, 0);

        req_addr = {32'h0000_0004, 32'h0000_0010};
        req_data = {32'h0000_0005, 32'h0000_0000};
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            req_valid     = vecs[i].valid;
            req_write     = vecs[i].write;
            csr_req_ready = vecs[i].rdy;
            csr_rsp_valid = vecs[i].rspv;
            csr_rsp_data  = vecs[i].rspd;
            rsp_ready     = vecs[i].rsprdy;
            #1;
            $display("vec %0d: valid=%b write=%b cv=%b addr=%h rdy_o=%b rspv_o=%b out=%0d err=%b",
                     i, req_valid, req_write, csr_req_valid, csr_req_addr, req_ready,
                     rsp_valid, outstanding, err);
            check($sformatf("vec%0d_csr_valid", i), 64'(csr_req_valid), 64'(vecs[i].e_cv));
            if (vecs[i].e_cv)
                check($sformatf("vec%0d_csr_addr", i), 64'(csr_req_addr), 64'(vecs[i].e_addr));
            check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_rr));
            check($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rv));
            check($sformatf("vec%0d_csr_rsp_ready", i), 64'(csr_rsp_ready), 64'(vecs[i].e_crr));
            check($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].e_err));
            check($sformatf("vec%0d_rsp_data", i), 64'(rsp_data), {vecs[i].rspd, vecs[i].rspd});
        end

        // ---------------------------------------------------------------
        // Back-pressure: requester 1 held for 3 cycles, requester 0 joins
        // in the second cycle and must wait for requester 1's handshake.
        // ---------------------------------------------------------------
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        req_addr = {32'h0000_0204, 32'h0000_0100};
        for (int c = 0; c < 4; c++) begin
            req_valid     = (c == 0) ? 2'b10 : 2'b11;
            req_write     = 2'b00;
            csr_req_ready = (c == 3);
            #1;
            $display("bp cycle %0d: addr=%h rdy_o=%b", c, csr_req_addr, req_ready);
            check("bp_valid", 64'(csr_req_valid), 64'd1);
            check("bp_addr", 64'(csr_req_addr), 64'h204);
            check("bp_ready", 64'(req_ready), (c == 3) ? 64'h2 : 64'h0);
            @(negedge clk);
        end
        req_valid = 2'b01;
        #1;
        $display("bp next: addr=%h rdy_o=%b", csr_req_addr, req_ready);
        check("bp_next_addr", 64'(csr_req_addr), 64'h100);
        check("bp_next_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("bp_outstanding", 64'(outstanding), 64'd2);

        // Reset with two reads in flight, then a late response arrives.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("mid reset: out=%0d err=%b", outstanding, err);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_csr_valid", 64'(csr_req_valid), 64'd0);
        check("rst_csr_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        @(negedge clk);
        csr_rsp_valid = 1'b1;
        csr_rsp_data  = 32'hCAFE_0001;
        #1;
        check("late_rsp_ready", 64'(csr_rsp_ready), 64'd1);
        check("late_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        csr_rsp_valid = 1'b0;
        #1;
        $display("late response: err=%b", err);
        check("late_rsp_err", 64'(err), 64'd1);

        // ---------------------------------------------------------------
        // Randomised traffic against a queue-based reference model
        // ---------------------------------------------------------------
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        m_rr = 0; m_lock = 0; m_lidx = 0; m_q.delete(); m_err = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            bit          any, full, empty, stall, exp_cv, hs, do_rst;
            int          g, head;
            logic [N-1:0] exp_rr, exp_rv;
            logic        exp_crr;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i]   = 1;
                    p_addr[i] = $urandom;
                    p_data[i] = $urandom;
                    p_wr[i]   = ($urandom_range(2, 0) == 0);
                end
                req_valid[i]          = pend[i];
                req_write[i]          = pend[i] ? p_wr[i] : 1'b0;
                req_addr[i*32 +: 32]  = p_addr[i];
                req_data[i*32 +: 32]  = p_data[i];
            end
            csr_req_ready = ($urandom_range(3, 0) != 0);
            csr_rsp_valid = (m_q.size() > 0) ? ($urandom_range(1, 0) == 1)
                                             : ($urandom_range(15, 0) == 0);
            csr_rsp_data  = $urandom;
            rsp_ready     = N'($urandom);
            do_rst        = ($urandom_range(99, 0) == 0);
            rst           = do_rst;
            #1;

            // Expected behaviour from the arbitration and routing rules
            any = (req_valid != '0);
            g   = -1;
            if (m_lock) g = m_lidx;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g < 0) g = m_rr;
            full    = (m_q.size() == M);
            empty   = (m_q.size() == 0);
            stall   = full && !req_write[g];
            exp_cv  = any && !stall;
            hs      = exp_cv && csr_req_ready;
            exp_rr  = hs ? (N'(1) << g) : '0;
            head    = empty ? 0 : m_q[0];
            exp_rv  = (!empty && csr_rsp_valid) ? (N'(1) << head) : '0;
            exp_crr = empty ? csr_rsp_valid : rsp_ready[head];

            check("rnd_csr_valid", 64'(csr_req_valid), 64'(exp_cv));
            if (exp_cv) begin
                check("rnd_csr_addr", 64'(csr_req_addr), 64'(p_addr[g]));
                check("rnd_csr_data", 64'(csr_req_data), 64'(p_data[g]));
                check("rnd_csr_write", 64'(csr_req_write), 64'(p_wr[g]));
            end
            check("rnd_req_ready", 64'(req_ready), 64'(exp_rr));
            check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("rnd_csr_rsp_ready", 64'(csr_rsp_ready), 64'(exp_crr));
            check("rnd_outstanding", 64'(outstanding), 64'(m_q.size()));
            check("rnd_err", 64'(err), 64'(m_err));

            if (hs) begin
                $display("rnd %0d: r%0d %s addr=%h", cyc, g, p_wr[g] ? "write" : "read", p_addr[g]);
                pend[g] = 0;
            end
            if (exp_rv != '0)
                $display("rnd %0d: rsp -> r%0d data=%h", cyc, head, csr_rsp_data);

            if (do_rst) begin
                m_rr = 0; m_lock = 0; m_lidx = 0; m_q.delete(); m_err = 0;
            end else begin
                if (csr_rsp_valid && empty) m_err = 1;
                if (!empty && csr_rsp_valid && rsp_ready[head]) void'(m_q.pop_front());
                if (hs) begin
                    m_rr = (g + 1) % N;
                    if (!req_write[g]) m_q.push_back(g);
                end
                m_lock = any && !hs;
                m_lidx = g;
            end
            @(negedge clk);
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
